// File: rtl/masked_sbox_pkg.sv
// -----------------------------------------------------------------------------
// masked_sbox_pkg
//
// Shared definitions for the masked AES S-box datapath.
//   SHARE_W           width of one Boolean share
//   INV_AFFINE_CONST  constant of the AES inverse affine transform
//   FWD_AFFINE_CONST  constant of the AES forward affine transform
//   share_t           one share of a byte
//   inv_affine_lin()  linear part L of the inverse affine transform:
//                       y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8]
//                     L is linear over GF(2), so it can be applied to each
//                     share independently without unmasking.
// -----------------------------------------------------------------------------
package masked_sbox_pkg;

  localparam int unsigned SHARE_W = 8;

  localparam logic [SHARE_W-1:0] INV_AFFINE_CONST = 8'h05;
  localparam logic [SHARE_W-1:0] FWD_AFFINE_CONST = 8'h63;

  typedef logic [SHARE_W-1:0] share_t;

  function automatic share_t inv_affine_lin(input share_t x);
    share_t y;
    y = '0;
    for (int unsigned i = 0; i < SHARE_W; i++) begin
      y[i] = x[(i + 2) % SHARE_W] ^ x[(i + 5) % SHARE_W] ^ x[(i + 7) % SHARE_W];
    end
    return y;
  endfunction

endpackage

// File: rtl/masked_refresh_reg.sv
// -----------------------------------------------------------------------------
// masked_refresh_reg
//
// Two-share output register that re-randomises both shares with the same
// fresh mask r on load. Since both shares receive the same r, the unmasked
// value (q0 ^ q1) equals (d0 ^ d1), while each individual share becomes
// independent of its previous value.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high; clears both shares
//   load  load enable; r is only sampled in a cycle where load is high
//   d0    share 0 in
//   d1    share 1 in
//   r     fresh randomness
//   q0    registered share 0 (d0 ^ r)
//   q1    registered share 1 (d1 ^ r)
// -----------------------------------------------------------------------------
module masked_refresh_reg
  import masked_sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] r,
  output logic [7:0] q0,
  output logic [7:0] q1
);

  // Each share lives in its own always block so the two shares never meet
  // in a common combinational cloud.
  always_ff @(posedge clk) begin : share0_reg
    if (rst) begin
      q0 <= '0;
    end else if (load) begin
      q0 <= d0 ^ r;
    end
  end

  always_ff @(posedge clk) begin : share1_reg
    if (rst) begin
      q1 <= '0;
    end else if (load) begin
      q1 <= d1 ^ r;
    end
  end

endmodule

// File: rtl/masked_inv_affine_stage.sv
// -----------------------------------------------------------------------------
// masked_inv_affine_stage
//
// Two-share (first-order Boolean masked) AES inverse affine transform.
// Takes a shared S-box-domain byte and produces the shared GF(2^8)-inverse
// domain byte for the following masked inversion gadget.
//   share 0: L(in0) ^ CONST
//   share 1: L(in1)
// so that out0 ^ out1 = L(in0 ^ in1) ^ CONST. The final register refreshes
// both shares with fresh randomness r.
//
// Parameters:
//   pipeline  1: transform register (stage A) followed by refresh register
//                (stage B); 2-cycle latency.
//             0: transform and refresh in a single register; 1-cycle latency.
//   CONST     inverse-affine constant, applied to share 0 only.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high, priority over all loads
//   in_valid   input shares valid
//   in_ready   stage can accept input this cycle
//   in0, in1   input shares
//   r          fresh randomness, sampled only when the refresh register loads
//   out_valid  output shares valid
//   out_ready  downstream accepts output
//   out0, out1 output shares
//   busy       any stage holds valid data
// -----------------------------------------------------------------------------
module masked_inv_affine_stage
  import masked_sbox_pkg::*;
#(
  parameter int                 pipeline = 1,
  parameter logic [SHARE_W-1:0] CONST    = INV_AFFINE_CONST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic       busy
);

  // Per-share linear transform; kept in separate blocks so no net ever
  // mixes bits of in0 and in1 ahead of a register.
  logic [7:0] t0;
  logic [7:0] t1;

  always_comb begin : share0_map
    t0 = inv_affine_lin(in0) ^ CONST;
  end

  always_comb begin : share1_map
    t1 = inv_affine_lin(in1);
  end

  // Data and load enable presented to the refresh register (stage B).
  logic [7:0] b_d0;
  logic [7:0] b_d1;
  logic       b_load;

  generate
    if (pipeline != 0) begin : g_two_stage
      logic [7:0] a0;
      logic [7:0] a1;
      logic       a_v;
      logic       a_load;

      // Stage A can take new data if it is empty, or if stage B will take
      // stage A's current content this cycle (B empty or draining).
      assign in_ready = !a_v || !out_valid || out_ready;
      assign a_load   = in_valid && in_ready;
      assign b_load   = a_v && (!out_valid || out_ready);

      always_ff @(posedge clk) begin : stage_a_share0
        if (rst) begin
          a0 <= '0;
        end else if (a_load) begin
          a0 <= t0;
        end
      end

      always_ff @(posedge clk) begin : stage_a_share1
        if (rst) begin
          a1 <= '0;
        end else if (a_load) begin
          a1 <= t1;
        end
      end

      // A refill in the same cycle as a hand-over to B keeps a_v set.
      always_ff @(posedge clk) begin : stage_a_valid
        if (rst) begin
          a_v <= 1'b0;
        end else if (a_load) begin
          a_v <= 1'b1;
        end else if (b_load) begin
          a_v <= 1'b0;
        end
      end

      assign b_d0 = a0;
      assign b_d1 = a1;
      assign busy = a_v | out_valid;
    end else begin : g_one_stage
      assign in_ready = !out_valid || out_ready;
      assign b_load   = in_valid && in_ready;
      assign b_d0     = t0;
      assign b_d1     = t1;
      assign busy     = out_valid;
    end
  endgenerate

  // Output valid: set on a refresh-register load, cleared when consumed
  // without a replacement.
  always_ff @(posedge clk) begin : stage_b_valid
    if (rst) begin
      out_valid <= 1'b0;
    end else if (b_load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  masked_refresh_reg u_refresh (
    .clk  (clk),
    .rst  (rst),
    .load (b_load),
    .d0   (b_d0),
    .d1   (b_d1),
    .r    (r),
    .q0   (out0),
    .q1   (out1)
  );

endmodule

// File: tb/tb_masked_inv_affine_stage.sv
// -----------------------------------------------------------------------------
// tb_masked_inv_affine_stage
//
// Self-checking bench for masked_inv_affine_stage. Two instances are built,
// one with pipeline=1 and one with pipeline=0; sel_p0 routes the shared
// stimulus to one of them and selects which outputs are observed.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, well away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_masked_inv_affine_stage;
  import masked_sbox_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in0, in1, r;
  logic       out_ready;
  logic       sel_p0;

  logic       p1_in_ready, p1_out_valid, p1_busy;
  logic [7:0] p1_out0, p1_out1;
  logic       p0_in_ready, p0_out_valid, p0_busy;
  logic [7:0] p0_out0, p0_out1;

  logic       m_in_ready, m_out_valid, m_busy;
  logic [7:0] m_out0, m_out1;

  always #5 clk = ~clk;

  masked_inv_affine_stage #(.pipeline(1), .CONST(INV_AFFINE_CONST)) u_dut_p1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !sel_p0),
    .in_ready  (p1_in_ready),
    .in0       (in0),
    .in1       (in1),
    .r         (r),
    .out_valid (p1_out_valid),
    .out_ready (out_ready),
    .out0      (p1_out0),
    .out1      (p1_out1),
    .busy      (p1_busy)
  );

  masked_inv_affine_stage #(.pipeline(0), .CONST(INV_AFFINE_CONST)) u_dut_p0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel_p0),
    .in_ready  (p0_in_ready),
    .in0       (in0),
    .in1       (in1),
    .r         (r),
    .out_valid (p0_out_valid),
    .out_ready (out_ready),
    .out0      (p0_out0),
    .out1      (p0_out1),
    .busy      (p0_busy)
  );

  assign m_in_ready  = sel_p0 ? p0_in_ready  : p1_in_ready;
  assign m_out_valid = sel_p0 ? p0_out_valid : p1_out_valid;
  assign m_busy      = sel_p0 ? p0_busy      : p1_busy;
  assign m_out0      = sel_p0 ? p0_out0      : p1_out0;
  assign m_out1      = sel_p0 ? p0_out1      : p1_out1;

  // ---------------------------------------------------------------------------
  // Reference arithmetic: GF(2^8) inverse and forward affine, used to build
  // S-box inputs whose expected result is the GF inverse of the plaintext.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] c;
    if (a == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      c = 8'(y);
      if (gmul(a, c) == 8'h01) return c;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] k;
    k = FWD_AFFINE_CONST;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
           ^ x[(i + 7) % 8] ^ k[i];
    end
    return y;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         n_acc, n_out;
  logic       pstall;
  logic [7:0] p_o0, p_o1;

  // One clock cycle of handshake traffic with scoreboard bookkeeping.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] rr, input logic ordy, input logic [7:0] ex);
    logic [7:0] e;
    @(negedge clk);
    in_valid  = v;
    in0       = a;
    in1       = b;
    r         = rr;
    out_ready = ordy;
    #1;
    if (pstall) begin
      chk("stall_valid", {31'd0, m_out_valid}, 32'd1);
      chk("stall_shares", {16'd0, m_out0, m_out1}, {16'd0, p_o0, p_o1});
    end
    pstall = m_out_valid && !ordy;
    p_o0   = m_out0;
    p_o1   = m_out1;
    if (m_out_valid && ordy) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {24'd0, m_out0 ^ m_out1}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_unmasked", {24'd0, m_out0 ^ m_out1}, {24'd0, e});
      end
    end
    if (v && m_in_ready) begin
      exp_q.push_back(ex);
      n_acc++;
    end
  endtask

  task automatic start_scenario();
    exp_q.delete();
    n_acc  = 0;
    n_out  = 0;
    pstall = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed single-transaction vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] i0;
    logic [7:0] i1;
    logic [7:0] rr;
    logic [7:0] unm;
  } vec_t;

  vec_t vt[7];

  task automatic apply_vec(input vec_t v, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in0       = v.i0;
    in1       = v.i1;
    r         = v.rr;
    out_ready = 1'b1;
    #1;
    chk("vec_in_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!m_out_valid && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("vec_latency", lat, exp_lat);
    chk("vec_unmasked", {24'd0, m_out0 ^ m_out1}, {24'd0, v.unm});
    chk("vec_out1", {24'd0, m_out1}, {24'd0, inv_affine_lin(v.i1) ^ v.rr});
  endtask

  // Backpressure: 5 stalled cycles offering 4 inputs, then release.
  logic [7:0] bp_s[4];
  logic [7:0] bp_e[4];

  task automatic backpressure(input int exp_acc);
    int j, idx;
    logic [7:0] m;
    start_scenario();
    j = 0;
    for (int c = 0; c < 5; c++) begin
      idx = (j < 4) ? j : 0;
      m = 8'($urandom);
      cyc(j < 4, bp_s[idx] ^ m, m, 8'($urandom), 1'b0, bp_e[idx]);
      j = n_acc;
    end
    chk("bp_accepted_stalled", n_acc, exp_acc);
    for (int c = 0; c < 40; c++) begin
      if (j == 4 && exp_q.size() == 0 && !m_out_valid) break;
      idx = (j < 4) ? j : 0;
      m = 8'($urandom);
      cyc(j < 4, bp_s[idx] ^ m, m, 8'($urandom), 1'b1, bp_e[idx]);
      j = n_acc;
    end
    chk("bp_accepted_total", n_acc, 4);
    chk("bp_outputs_total", n_out, 4);
    chk("bp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] p;

    // {in0, in1, r, expected out0^out1}
    vt[0] = '{8'h63, 8'h00, 8'h00, 8'h00};
    vt[1] = '{8'hD9, 8'hA5, 8'h3C, 8'h01};  // 0x7C masked with 0xA5
    vt[2] = '{8'h00, 8'h00, 8'h5A, 8'h05};
    vt[3] = '{8'hFF, 8'h00, 8'hC3, 8'hFA};
    vt[4] = '{8'h49, 8'h3E, 8'h81, 8'h8D};  // 0x77 masked with 0x3E
    vt[5] = '{8'h8B, 8'hF0, 8'hFF, 8'hF6};  // 0x7B masked with 0xF0
    vt[6] = '{8'h5A, 8'h5A, 8'h11, 8'h05};  // unmasked 0x00
    bp_s = '{8'h63, 8'h7C, 8'h77, 8'h7B};
    bp_e = '{8'h00, 8'h01, 8'h8D, 8'hF6};

    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; r = '0;
    out_ready = 1'b0; sel_p0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_p1", {11'd0, p1_in_ready, p1_out_valid, p1_busy, p1_out0, p1_out1},
        {11'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    chk("reset_p0", {11'd0, p0_in_ready, p0_out_valid, p0_busy, p0_out0, p0_out1},
        {11'd0, 1'b1, 1'b0, 1'b0, 16'h0000});

    // Directed vectors on both builds.
    sel_p0 = 1'b0;
    for (int i = 0; i < 7; i++) apply_vec(vt[i], 2);
    sel_p0 = 1'b1;
    for (int i = 0; i < 7; i++) apply_vec(vt[i], 1);

    // Backpressure on both builds.
    sel_p0 = 1'b0;
    backpressure(2);
    sel_p0 = 1'b1;
    backpressure(1);

    // Stream all 256 plaintexts through the two-stage build.
    sel_p0 = 1'b0;
    start_scenario();
    for (int i = 0; i < 256; i++) begin
      p = 8'(i);
      m = 8'($urandom);
      cyc(1'b1, fwd_affine(gf_inv(p)) ^ m, m, 8'($urandom), 1'b1, gf_inv(p));
    end
    chk("stream_accepted", n_acc, 256);
    for (int c = 0; c < 10; c++) begin
      if (exp_q.size() == 0) break;
      cyc(1'b0, 8'h00, 8'h00, 8'($urandom), 1'b1, 8'h00);
    end
    chk("stream_outputs", n_out, 256);

    // Reset with both stages full.
    start_scenario();
    for (int c = 0; c < 3; c++) begin
      m = 8'($urandom);
      cyc(1'b1, bp_s[c] ^ m, m, 8'($urandom), 1'b0, bp_e[c]);
    end
    chk("full_before_reset", {30'd0, m_busy, m_out_valid}, 32'd3);
    chk("full_in_ready", {31'd0, m_in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in0 = 8'hAA; in1 = 8'h55; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_mid_state", {11'd0, m_in_ready, m_out_valid, m_busy, m_out0, m_out1},
        {11'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    start_scenario();
    for (int c = 0; c < 5; c++) cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00);
    chk("rst_no_ghost_output", n_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/masked_inv_affine_stage.md
Name: masked_inv_affine_stage

Overview:
- Two-share (first-order Boolean-masked) inverse AES affine transform: the reverse direction of the forward S-box output layer.
- Accepts a shared S-box-domain byte and produces the shared GF(2^8)-inverse-domain byte, ready to feed a masked inversion gadget.
- Uses a valid/ready pipeline with a fresh-randomness refresh on the final register.
- Sits at the front of the masked inverse S-box (decryption) datapath.

Parameters:
- pipeline, 1: 1 gives two register stages (transform, then refresh); 0 gives a single stage (transform and refresh in one register).
- CONST, 8'h05: inverse-affine constant, XORed into share 0 only.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input shares valid
- in_ready  output  1  stage can accept input this cycle
- in0  input  8  share 0 of input byte
- in1  input  8  share 1 of input byte
- r  input  8  fresh randomness for refresh; sampled only on refresh-register load
- out_valid  output  1  output shares valid
- out_ready  input  1  downstream accepts output
- out0  output  8  share 0 of result
- out1  output  8  share 1 of result
- busy  output  1  any pipeline stage holds valid data

Behaviour:
- Linear map L, applied per share independently (indices mod 8): y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8].
- Share 0 result: L(in0) ^ CONST. Share 1 result: L(in1), with no constant.
- Unmasked result: (out0 ^ out1) = L(in0 ^ in1) ^ 8'h05, i.e. the AES inverse affine.
- Shares never combined: no net mixes in0 and in1 bits before a register. Each share is computed in a separate always/assign group.
- Refresh: out0 = t0 ^ r, out1 = t1 ^ r, registered. r is sampled only in a cycle where the refresh register loads; otherwise ignored.
- pipeline=1:
  - Stage A registers (a0, a1, a_v) load the transformed shares when in_valid && in_ready.
  - Stage B registers (out0, out1, out_valid) load the refreshed stage-A data when a_v && (!out_valid || out_ready).
  - in_ready = !a_v || (!out_valid || out_ready).
  - Latency: 2 cycles from accept to out_valid. Throughput: 1 byte/cycle when out_ready is held high.
- pipeline=0: one register set. in_ready = !out_valid || out_ready. Latency 1 cycle.
- Stall: while out_valid && !out_ready, out0/out1/out_valid hold stable. Stage A fills once and then in_ready deasserts. No data loss and no duplication.
- Simultaneous events:
  - Stage B consume and stage A refill in the same cycle are legal.
  - A full pipe with out_ready=1 accepts a new input every cycle.
- busy = a_v | out_valid (pipeline=1), or out_valid (pipeline=0).
- Reset (synchronous, takes priority over all loads):
  - a_v, out_valid cleared to 0.
  - a0, a1, out0, out1 cleared to 8'h00.
  - in_ready = 1 in the cycle after reset; busy = 0.
- Reset mid-operation discards in-flight bytes; no output is emitted for them.
- in_valid is ignored while rst is high.
- No combinational path from in_valid to out_valid. in_ready depends combinationally only on registered state and out_ready.

Decomposition:
- Shared package masked_sbox_pkg:
  - SHARE_W = 8
  - INV_AFFINE_CONST = 8'h05
  - FWD_AFFINE_CONST = 8'h63
  - a function inv_affine_lin(x) implementing L, reused by both the RTL and the testbench model.
- One sub-module is natural: masked_refresh_reg (two 8-bit shares, r input, load enable, sync reset), instantiated once as stage B.

Test Plan:
- Unmasked 0x63 (in0=8'h63, in1=8'h00, r=8'h00), out_ready=1 -> out_valid 2 cycles after accept; out0^out1 = 8'h00.
- Masked 0x7C (in0=8'h7C^8'hA5, in1=8'hA5, r=8'h3C) -> out0^out1 = 8'h01; out1 = L(8'hA5)^8'h3C.
- Streaming all 256 values with random masks and r, out_ready=1 -> one result per cycle, in order. Each unmasked output equals the GF inverse of the plaintext byte (checked against the S-box table); in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles while driving 4 inputs -> exactly 2 accepted, out0/out1 stable. After out_ready=1, the remaining inputs are accepted with no loss or duplication, in order.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, busy=0, out0=out1=8'h00, in_ready=1. The discarded bytes never appear at the output.
- pipeline=0 build: repeat the first and fourth scenarios -> latency 1 cycle, identical unmasked results.
